instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/pc_register.sv | 35 +++
 rtl/instruction_fetch.sv | 126 ++++++++++++
 tb/tb_instruction_fetch.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: word/address widths, PC step, fetch FSM states.
// The alignment helper forces the low two address bits to zero.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_INCR = ADDR_W'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter with redirect load and sequential increment; redirect wins over increment.
// pc_next is the value the register takes on the coming edge, so callers can latch it in the same cycle.
module pc_register
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              incr,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] pc;

  always_comb begin
    pc_next = pc;
    if (load) begin
      pc_next = word_align(load_addr);
    end else if (incr) begin
      pc_next = pc + PC_INCR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem read, ack in cycle N presents the word in N+1 (2 cycles/instr best case).
// Holds the presented word until decode accepts it; a redirect discards any in-flight or held word.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  inst_pc,
  output logic               inst_valid,
  input  logic               inst_ready
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] pc_next;
  logic              pc_load;
  logic              capture;
  logic              req_load;
  logic              valid_clr;
  logic              transfer;

  assign transfer  = inst_valid && inst_ready;
  assign imem_req  = (state == REQ) || (state == FLUSH);
  assign imem_addr = req_addr;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (branch_target),
    .incr      (capture),
    .pc_next   (pc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Every entry into REQ latches req_addr from pc_next, so a redirect taken
  // in the same cycle is fetched directly.
  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    capture    = 1'b0;
    req_load   = 1'b0;
    valid_clr  = 1'b0;
    case (state)
      IDLE: begin
        pc_load    = branch_taken;
        req_load   = 1'b1;
        state_next = REQ;
      end
      REQ: begin
        if (branch_taken) begin
          pc_load = 1'b1;
          if (imem_ack) begin
            req_load   = 1'b1;
            state_next = REQ;
          end else begin
            state_next = FLUSH;
          end
        end else if (imem_ack) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        pc_load   = branch_taken;
        valid_clr = branch_taken || transfer;
        if (branch_taken || transfer) begin
          req_load   = 1'b1;
          state_next = REQ;
        end
      end
      FLUSH: begin
        pc_load = branch_taken;
        if (imem_ack) begin
          req_load   = 1'b1;
          state_next = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr <= RESET_PC;
    end else if (req_load) begin
      req_addr <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= '0;
      inst_pc     <= '0;
      inst_valid  <= 1'b0;
    end else if (capture) begin
      instruction <= imem_rdata;
      inst_pc     <= req_addr;
      inst_valid  <= 1'b1;
    end else if (valid_clr) begin
      inst_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboarded bench for instruction_fetch: memory returns addr^KEY, model predicts the delivered stream.
// Directed scenarios first, then randomized acks/ready/branches/resets, plus a wrap-around instance.
module tb_instruction_fetch;

  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst, branch_taken, imem_req, imem_ack, inst_valid, inst_ready;
  logic [31:0] branch_target, imem_addr, imem_rdata, instruction, inst_pc;

  logic        rst_w, branch_w, req_w, ack_w, valid_w, ready_w;
  logic [31:0] target_w, addr_w, rdata_w, instr_w, pc_w;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_fetch;
  logic [31:0] xfer_pc[$];
  int          xfer_cyc[$];
  logic [31:0] wq_pc[$];
  logic [31:0] wq_data[$];
  logic [31:0] last_pc;
  int          total = 0;
  int          bad = 0;
  int          n_xfer = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready)
  );

  assign branch_w = 1'b0;
  assign target_w = 32'h0;
  assign ready_w  = 1'b1;
  assign ack_w    = req_w;
  assign rdata_w  = addr_w ^ KEY;

  instruction_fetch #(.RESET_PC(WRAP_PC)) dut_w (
    .clk(clk), .rst(rst_w), .branch_taken(branch_w), .branch_target(target_w),
    .imem_req(req_w), .imem_addr(addr_w), .imem_ack(ack_w), .imem_rdata(rdata_w),
    .instruction(instr_w), .inst_pc(pc_w), .inst_valid(valid_w), .inst_ready(ready_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs and updates the reference model with what the
  // coming clock edge will do: a live ack at the expected fetch address joins
  // the stream, a redirect restarts the stream at the aligned target.
  task automatic drive(input bit r, input bit b, input logic [31:0] tgt,
                       input bit a, input bit rdy, input bit stray = 1'b0);
    @(posedge clk);
    #1;
    rst           = r;
    branch_taken  = b;
    branch_target = tgt;
    inst_ready    = rdy;
    imem_ack      = stray | (a & imem_req);
    imem_rdata    = imem_ack ? (imem_addr ^ KEY) : $urandom;
    if (r) begin
      exp_q.delete();
      exp_fetch = RESET_PC;
    end else begin
      if (imem_ack && imem_req && !b && imem_addr == exp_fetch) begin
        exp_q.push_back('{pc: imem_addr, data: imem_addr ^ KEY});
        exp_fetch = exp_fetch + 32'd4;
      end
      if (b) begin
        if (!(inst_valid && rdy)) exp_q.delete();
        exp_fetch = {tgt[31:2], 2'b00};
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Monitor: compares every transfer against the scoreboard and checks
  // cycle-to-cycle stability rules.
  logic        prev_hold = 1'b0, prev_xfer = 1'b0, prev_wait = 1'b0;
  logic [31:0] prev_addr = '0, prev_instr = '0, prev_pc = '0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      check("req_while_valid", {31'd0, inst_valid & imem_req}, 32'd0);
      if (imem_req) check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      if (prev_hold) begin
        check("hold_valid", {31'd0, inst_valid}, 32'd1);
        check("hold_instr", instruction, prev_instr);
        check("hold_pc", inst_pc, prev_pc);
      end
      if (prev_xfer) check("valid_clear_after_xfer", {31'd0, inst_valid}, 32'd0);
      if (prev_wait) begin
        check("req_kept", {31'd0, imem_req}, 32'd1);
        check("req_addr_stable", imem_addr, prev_addr);
      end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL xfer_unexpected: got pc=%h data=%h expected no transfer", inst_pc, instruction);
        end else begin
          e = exp_q.pop_front();
          check("xfer_pc", inst_pc, e.pc);
          check("xfer_data", instruction, e.data);
        end
        n_xfer++;
        last_pc = inst_pc;
        xfer_pc.push_back(inst_pc);
        xfer_cyc.push_back(cyc);
      end
    end
    prev_hold  = !rst && inst_valid && !inst_ready && !branch_taken;
    prev_xfer  = !rst && inst_valid && inst_ready;
    prev_wait  = !rst && imem_req && !imem_ack;
    prev_addr  = imem_addr;
    prev_instr = instruction;
    prev_pc    = inst_pc;
  end

  always @(negedge clk) begin
    if (!rst_w && valid_w) begin
      wq_pc.push_back(pc_w);
      wq_data.push_back(instr_w);
    end
  end

  initial begin
    rst_w = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_w = 1'b0;
  end

  initial begin
    int n0;
    int n1;
    logic [31:0] tgt;
    rst = 1'b1; branch_taken = 1'b0; branch_target = '0;
    imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    exp_fetch = RESET_PC;

    // Reset values, then zero-wait streaming at 2 cycles per instruction.
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_instruction", instruction, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    n0 = xfer_pc.size();
    repeat (8) drive(0, 0, 0, 1, 1);
    settle();
    check("stream_count", xfer_pc.size() - n0, 32'd4);
    if (xfer_pc.size() >= n0 + 4) begin
      for (int k = 0; k < 4; k++) begin
        check("stream_pc", xfer_pc[n0+k], 32'(4 * k));
        if (k > 0) check("stream_interval", 32'(xfer_cyc[n0+k] - xfer_cyc[n0+k-1]), 32'd2);
      end
    end

    // Decode stalls for 5 cycles with a word held.
    drive(0, 0, 0, 1, 0);
    repeat (5) drive(0, 0, 0, 0, 0);
    settle();
    check("stall_valid", {31'd0, inst_valid}, 32'd1);
    check("stall_pc", inst_pc, 32'h10);
    check("stall_data", instruction, 32'h10 ^ KEY);
    check("stall_no_req", {31'd0, imem_req}, 32'd0);
    drive(0, 0, 0, 0, 1);

    // Slow ack on 0x8 with a redirect to 0x103 while waiting.
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 1, 32'h103, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    check("flush_addr_held", imem_addr, 32'h8);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1);
    settle();
    check("redirect_pc", last_pc, 32'h100);

    // Redirect together with a transfer out of HOLD.
    drive(0, 0, 0, 1, 0);
    drive(0, 1, 32'h40, 1, 1);
    drive(0, 0, 0, 0, 1);
    check("br_xfer_valid_clear", {31'd0, inst_valid}, 32'd0);
    check("br_xfer_addr", imem_addr, 32'h40);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1);
    settle();
    check("br_xfer_next_pc", last_pc, 32'h40);

    // Reset mid-request, then a stray ack while idle.
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
    check("mid_rst_instr", instruction, 32'd0);
    check("mid_rst_pc", inst_pc, 32'd0);
    drive(0, 0, 0, 1, 1);
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, RESET_PC);
    drive(0, 0, 0, 0, 1);
    settle();
    check("restart_pc", last_pc, RESET_PC);

    // Randomized traffic.
    n1 = n_xfer;
    repeat (3000) begin
      tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2047));
      drive($urandom_range(0, 249) == 0, $urandom_range(0, 11) == 0, tgt,
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
    end
    check("rand_progress", {31'd0, (n_xfer - n1) >= 300}, 32'd1);
    repeat (5) drive(0, 0, 0, 0, 1);
    settle();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    check("wrap_count", {31'd0, wq_pc.size() >= 3}, 32'd1);
    if (wq_pc.size() >= 3) begin
      check("wrap_pc0", wq_pc[0], WRAP_PC);
      check("wrap_data0", wq_data[0], WRAP_PC ^ KEY);
      check("wrap_pc1", wq_pc[1], 32'h0);
      check("wrap_data1", wq_data[1], KEY);
      check("wrap_pc2", wq_pc[2], 32'h4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
